// File: rtl/thin_window_feeder.sv
// Three-row window feeder for the thinning datapath: two line buffers hold rows r-2 and r-1,
// the incoming word is row r, and a single output register carries the aligned window.
module thin_window_feeder #(
    parameter int WORDS_PER_LINE = 8,
    parameter int LINES          = 8,
    parameter int DATA_W         = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_W-1:0]                 in_data,
    input  logic                              in_valid,
    input  logic                              in_sof,
    output logic                              in_ready,
    output logic [DATA_W-1:0]                 out_top,
    output logic [DATA_W-1:0]                 out_center,
    output logic [DATA_W-1:0]                 out_bottom,
    output logic [$clog2(WORDS_PER_LINE)-1:0] out_col,
    output logic                              out_eol,
    output logic                              out_eof,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int CW = $clog2(WORDS_PER_LINE);
    localparam int RW = $clog2(LINES);
    localparam logic [CW-1:0] LAST_COL = CW'(WORDS_PER_LINE - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(LINES - 1);
    localparam logic [RW-1:0] FILL_END = RW'(1);

    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [DATA_W-1:0] lb0_q [WORDS_PER_LINE];
    logic [DATA_W-1:0] lb1_q [WORDS_PER_LINE];

    logic            accept;
    logic            lb_we;
    logic            win_load;
    logic [CW-1:0]   wr_col;

    logic [DATA_W-1:0] top_q, center_q, bottom_q;
    logic [CW-1:0]   win_col_q;
    logic            eol_q, eof_q, valid_q;

    assign in_ready = (state_q == IDLE) || !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        lb_we    = 1'b0;
        win_load = 1'b0;
        wr_col   = in_sof ? '0 : col_q;
        if (accept) begin
            if (in_sof) begin
                // a start-of-frame word is always row 0, col 0, whatever the current state
                state_d = FILL;
                col_d   = CW'(1);
                row_d   = '0;
                lb_we   = 1'b1;
            end else if (state_q != IDLE) begin
                lb_we    = 1'b1;
                win_load = (state_q == STREAM);
                if (col_q == LAST_COL) begin
                    col_d = '0;
                    row_d = row_q + RW'(1);
                    if (state_q == FILL && row_q == FILL_END) begin
                        state_d = STREAM;
                    end else if (state_q == STREAM && row_q == LAST_ROW) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
        end
    end

    // stage boundary: control state and the output window register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            top_q     <= '0;
            center_q  <= '0;
            bottom_q  <= '0;
            win_col_q <= '0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (win_load) begin
                valid_q   <= 1'b1;
                top_q     <= lb1_q[wr_col];
                center_q  <= lb0_q[wr_col];
                bottom_q  <= in_data;
                win_col_q <= col_q;
                eol_q     <= (col_q == LAST_COL);
                eof_q     <= (col_q == LAST_COL) && (row_q == LAST_ROW);
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    // line buffers are never read before FILL rewrites them, so they carry no reset
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb1_q[wr_col] <= lb0_q[wr_col];
            lb0_q[wr_col] <= in_data;
        end
    end

    assign out_top    = top_q;
    assign out_center = center_q;
    assign out_bottom = bottom_q;
    assign out_col    = win_col_q;
    assign out_eol    = eol_q;
    assign out_eof    = eof_q;
    assign out_valid  = valid_q;

endmodule

// File: tb/tb_thin_window_feeder.sv
// Bench for thin_window_feeder: directed frames plus randomized traffic against a frame-level model.
module tb_thin_window_feeder;

    localparam int WPL = 4;
    localparam int LN  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic        in_ready;
    logic [31:0] out_top, out_center, out_bottom;
    logic [1:0]  out_col;
    logic        out_eol, out_eof, out_valid;
    logic        out_ready = 1'b0;

    thin_window_feeder #(.WORDS_PER_LINE(WPL), .LINES(LN), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof), .in_ready(in_ready),
        .out_top(out_top), .out_center(out_center), .out_bottom(out_bottom),
        .out_col(out_col), .out_eol(out_eol), .out_eof(out_eof),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] t, m, b, c;
        logic        eol, eof;
    } win_t;

    win_t        exp_q[$];
    win_t        log_q[$];
    win_t        ref_q[$];
    logic [32:0] items[$];
    int          idx;
    logic [31:0] img[LN][WPL];
    bit          m_active;
    int          m_k;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          eof_cnt;
    bit          rnd_valid, rnd_ready, hold_ready;
    int          stall_at, stall_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: a word's row/column is its position since the last in_sof.
    task automatic model_accept(input logic sof, input logic [31:0] d);
        int r, c;
        win_t w;
        if (sof) begin
            m_active = 1'b1;
            m_k = 0;
        end
        if (!m_active) return;
        r = m_k / WPL;
        c = m_k % WPL;
        img[r][c] = d;
        if (r >= 2) begin
            w.t = img[r-2][c];
            w.m = img[r-1][c];
            w.b = d;
            w.c = c;
            w.eol = (c == WPL - 1);
            w.eof = (c == WPL - 1) && (r == LN - 1);
            exp_q.push_back(w);
        end
        m_k++;
        if (m_k == LN * WPL) m_active = 1'b0;
    endtask

    task automatic check_cycle();
        bit ev, er;
        win_t w, o;
        ev = (exp_q.size() != 0);
        er = !m_active || !ev || out_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (ev) begin
            w = exp_q[0];
            chk("out_top", out_top, w.t);
            chk("out_center", out_center, w.m);
            chk("out_bottom", out_bottom, w.b);
            chk("out_col", 32'(out_col), w.c);
            chk("out_eol", 32'(out_eol), 32'(w.eol));
            chk("out_eof", 32'(out_eof), 32'(w.eof));
            if (out_ready) begin
                void'(exp_q.pop_front());
                o.t = out_top; o.m = out_center; o.b = out_bottom;
                o.c = 32'(out_col); o.eol = out_eol; o.eof = out_eof;
                log_q.push_back(o);
                if (out_eof) eof_cnt++;
            end
        end
        if (in_valid && er) begin
            model_accept(in_sof, in_data);
            idx++;
        end
    endtask

    task automatic run(input int budget, input bit must_finish);
        int cyc = 0;
        int scnt = 0;
        forever begin
            if (must_finish && idx >= items.size() && exp_q.size() == 0) break;
            if (cyc >= budget) begin
                if (must_finish) chk("timeout_pending", 32'(exp_q.size() + items.size() - idx), 32'd0);
                break;
            end
            if (idx < items.size() && (!rnd_valid || $urandom_range(0, 3) != 0)) begin
                in_valid = 1'b1;
                {in_sof, in_data} = items[idx];
            end else begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                in_data  = $urandom;
            end
            if (stall_at >= 0 && out_valid && log_q.size() == stall_at && scnt < stall_len) begin
                out_ready = 1'b0;
                scnt++;
            end else if (hold_ready) begin
                out_ready = 1'b0;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        in_sof = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_top", out_top, 32'd0);
        chk("rst_out_center", out_center, 32'd0);
        chk("rst_out_bottom", out_bottom, 32'd0);
        chk("rst_out_col", 32'(out_col), 32'd0);
        chk("rst_out_eol", 32'(out_eol), 32'd0);
        chk("rst_out_eof", 32'(out_eof), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        m_active = 1'b0;
        m_k = 0;
    endtask

    task automatic start_test();
        log_q.delete();
        items.delete();
        idx = 0;
        eof_cnt = 0;
        stall_at = -1;
        stall_len = 0;
        rnd_valid = 1'b0;
        rnd_ready = 1'b0;
        hold_ready = 1'b0;
    endtask

    task automatic add_frame(input logic [31:0] base, input bit rnd, input int nwords);
        for (int k = 0; k < nwords; k++) begin
            logic [31:0] d;
            d = rnd ? $urandom : base + 32'((k / WPL) * 16 + (k % WPL));
            items.push_back({(k == 0), d});
        end
    endtask

    task automatic cmp_ref(input string tag);
        chk({tag, "_count"}, 32'(log_q.size()), 32'(ref_q.size()));
        for (int i = 0; i < log_q.size() && i < ref_q.size(); i++) begin
            chk({tag, "_top"}, log_q[i].t, ref_q[i].t);
            chk({tag, "_center"}, log_q[i].m, ref_q[i].m);
            chk({tag, "_bottom"}, log_q[i].b, ref_q[i].b);
            chk({tag, "_col"}, log_q[i].c, ref_q[i].c);
        end
    endtask

    initial begin
        do_reset();

        // Basic frame
        start_test();
        add_frame(32'h0, 1'b0, LN * WPL);
        run(60, 1'b1);
        chk("basic_count", 32'(log_q.size()), 32'd8);
        chk("basic_eof_count", 32'(eof_cnt), 32'd1);
        if (log_q.size() == 8) begin
            chk("basic_first_top", log_q[0].t, 32'h00);
            chk("basic_first_center", log_q[0].m, 32'h10);
            chk("basic_first_bottom", log_q[0].b, 32'h20);
            chk("basic_first_col", log_q[0].c, 32'd0);
            chk("basic_last_top", log_q[7].t, 32'h13);
            chk("basic_last_center", log_q[7].m, 32'h23);
            chk("basic_last_bottom", log_q[7].b, 32'h33);
            chk("basic_last_eol", 32'(log_q[7].eol), 32'd1);
            chk("basic_last_eof", 32'(log_q[7].eof), 32'd1);
        end
        ref_q = log_q;

        // Backpressure at the second window
        start_test();
        add_frame(32'h0, 1'b0, LN * WPL);
        stall_at = 1;
        stall_len = 3;
        run(60, 1'b1);
        if (log_q.size() > 1) begin
            chk("bp_top", log_q[1].t, 32'h01);
            chk("bp_center", log_q[1].m, 32'h11);
            chk("bp_bottom", log_q[1].b, 32'h21);
        end
        cmp_ref("bp");

        // Garbage before the first in_sof
        do_reset();
        start_test();
        for (int i = 0; i < 5; i++) items.push_back({1'b0, $urandom});
        add_frame(32'h0, 1'b0, LN * WPL);
        run(60, 1'b1);
        cmp_ref("presof");

        // Abort at row 2 col 1, then a full new frame
        start_test();
        add_frame(32'h0, 1'b0, 2 * WPL + 1);
        add_frame(32'h100, 1'b0, LN * WPL);
        run(80, 1'b1);
        chk("abort_count", 32'(log_q.size()), 32'd9);
        chk("abort_eof_count", 32'(eof_cnt), 32'd1);
        if (log_q.size() > 1) begin
            chk("abort_old_top", log_q[0].t, 32'h00);
            chk("abort_old_center", log_q[0].m, 32'h10);
            chk("abort_old_bottom", log_q[0].b, 32'h20);
            chk("abort_new_top", log_q[1].t, 32'h100);
            chk("abort_new_center", log_q[1].m, 32'h110);
            chk("abort_new_bottom", log_q[1].b, 32'h120);
        end

        // Reset while a window is stalled
        start_test();
        add_frame(32'h0, 1'b0, LN * WPL);
        hold_ready = 1'b1;
        run(2 * WPL + 4, 1'b0);
        chk("stall_before_reset_valid", 32'(out_valid), 32'd1);
        chk("stall_before_reset_in_ready", 32'(in_ready), 32'd0);
        do_reset();
        start_test();
        add_frame(32'h0, 1'b0, LN * WPL);
        run(60, 1'b1);
        cmp_ref("after_reset");

        // Back-to-back frames
        start_test();
        add_frame(32'h0, 1'b0, LN * WPL);
        add_frame(32'h100, 1'b0, LN * WPL);
        run(100, 1'b1);
        chk("b2b_count", 32'(log_q.size()), 32'd16);
        chk("b2b_eof_count", 32'(eof_cnt), 32'd2);

        // Random data with random valid/ready gaps
        start_test();
        items.push_back({1'b0, $urandom});
        items.push_back({1'b0, $urandom});
        for (int f = 0; f < 3; f++) add_frame(32'h0, 1'b1, LN * WPL);
        rnd_valid = 1'b1;
        rnd_ready = 1'b1;
        run(600, 1'b1);
        chk("rand_count", 32'(log_q.size()), 32'd24);
        chk("rand_eof_count", 32'(eof_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
